// File: rtl/hist_frame_ctrl.sv
// Frame sequencer for the histogram-equalisation pipeline: pixel framing, sink gating and LOAD/DRAIN/CLEAR sweeps.
// Optional macro HIST_FRAME_SKIP_EN: recompute the LUT only once every UPD_PERIOD frames.
module hist_frame_ctrl #(
  parameter int W          = 960,
  parameter int H          = 540,
  parameter int BINS       = 256,
  parameter int CDF_LAT    = 4,
  parameter int UPD_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        source_ready,
  output logic        pix_accept,
  output logic        sink_sop,
  output logic        sink_eop,
  output logic        data_load,
  output logic [7:0]  data_load_addr,
  output logic        clean,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {COLLECT, LOAD, DRAIN, CLEAR} state_t;

  localparam int AW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [AW-1:0] LAST_BIN   = AW'(BINS - 1);
  localparam logic [AW-1:0] LAST_DRAIN = AW'(CDF_LAT - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(W - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(H - 1);

  if (BINS < 2 || BINS > 256 || CDF_LAT < 1 || CDF_LAT > BINS || UPD_PERIOD < 1) begin : g_bad_param
    $error("hist_frame_ctrl: illegal parameter combination");
  end

  state_t        state, state_d;
  logic [AW-1:0] sweep, sweep_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          take_load;
  logic          frame_end;
  logic          from_reset;

  // Sink handshake and frame markers are purely combinational on the position counters.
  always_comb begin
    sink_ready = source_ready & (state == COLLECT);
    pix_accept = sink_valid & sink_ready;
    sink_sop   = pix_accept & (col == '0) & (row == '0);
    sink_eop   = pix_accept & (col == LAST_COL) & (row == LAST_ROW);
    busy       = (state != COLLECT);
  end

  // NOTE: every flop resets asynchronously and is written with <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_accept) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef HIST_FRAME_SKIP_EN
  localparam int SKW = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam logic [SKW-1:0] LAST_SKIP = SKW'(UPD_PERIOD - 1);
  logic [SKW-1:0] skip_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          skip_cnt <= '0;
    else if (sink_eop) skip_cnt <= (skip_cnt == LAST_SKIP) ? '0 : skip_cnt + 1'b1;
  end

  assign take_load = (skip_cnt == '0);
`else
  assign take_load = 1'b1;
`endif

  // A CLEAR sweep only advances once clean is actually on the bus, which
  // gives the reset-entered CLEAR its one idle lead-in cycle.
  assign frame_end = (state == CLEAR) & clean & (sweep == LAST_BIN);

  // NOTE: defaults first so no path through the case leaves a target unassigned (no latches).
  always_comb begin
    state_d = state;
    sweep_d = sweep;
    unique case (state)
      COLLECT: begin
        if (sink_eop) begin
          sweep_d = '0;
          state_d = take_load ? LOAD : CLEAR;
        end
      end
      LOAD: begin
        if (sweep == LAST_BIN) begin
          state_d = DRAIN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep + 1'b1;
        end
      end
      DRAIN: begin
        if (sweep == LAST_DRAIN) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else begin
          sweep_d = sweep + 1'b1;
        end
      end
      CLEAR: begin
        if (frame_end) begin
          state_d = COLLECT;
          sweep_d = '0;
        end else if (clean) begin
          sweep_d = sweep + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= CLEAR;
      sweep          <= '0;
      data_load      <= 1'b0;
      clean          <= 1'b0;
      data_load_addr <= '0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      from_reset     <= 1'b1;
    end else begin
      state          <= state_d;
      sweep          <= sweep_d;
      data_load      <= (state_d == LOAD);
      clean          <= (state_d == CLEAR);
      data_load_addr <= (state_d == LOAD || state_d == CLEAR) ? 8'(sweep_d) : 8'd0;
      frame_done     <= frame_end & ~from_reset;
      if (frame_end) begin
        from_reset <= 1'b0;
        if (!from_reset) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Self-checking bench for hist_frame_ctrl with a small frame (4x2) and a phase-offset reference model.
// Define HIST_FRAME_SKIP_EN on both files to exercise the frame-skip build.
module tb_hist_frame_ctrl;
  localparam int W          = 4;
  localparam int H          = 2;
  localparam int BINS       = 256;
  localparam int CDF_LAT    = 4;
  localparam int UPD_PERIOD = 4;
  localparam int PIX        = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        sink_valid;
  logic        sink_ready;
  logic        source_ready;
  logic        pix_accept;
  logic        sink_sop;
  logic        sink_eop;
  logic        data_load;
  logic [7:0]  data_load_addr;
  logic        clean;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  hist_frame_ctrl #(
    .W(W), .H(H), .BINS(BINS), .CDF_LAT(CDF_LAT), .UPD_PERIOD(UPD_PERIOD)
  ) dut (
    .clk(clk), .rst(rst),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .source_ready(source_ready),
    .pix_accept(pix_accept), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .data_load(data_load), .data_load_addr(data_load_addr), .clean(clean),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // {sink_ready, pix_accept, sink_sop, sink_eop, data_load, clean, busy, frame_done}
  logic [7:0] obs;
  assign obs = {sink_ready, pix_accept, sink_sop, sink_eop, data_load, clean, busy, frame_done};

  int checks = 0;
  int errors = 0;
  int acc    = 0;   // pixels accepted so far in the current frame
  int fc_exp = 0;   // expected completed-frame count
  int eops   = 0;   // frame ends seen since the last reset

  function automatic bit model_takes_load(input int eop_index);
`ifdef HIST_FRAME_SKIP_EN
    return (eop_index % UPD_PERIOD) == 0;
`else
    return (eop_index >= 0);
`endif
  endfunction

  // Streams pixels until the model's last pixel of the frame is accepted.
  task automatic stream_frame(input int mode);
    logic v, r, a, sop, eop;
    logic [7:0] exp;
    bit done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      case (mode)
        1:       begin v = 1'b1; r = (c % 3) != 2; end
        2:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
        default: begin v = 1'b1; r = 1'b1; end
      endcase
      sink_valid = v;
      source_ready = r;
      #1;
      a   = v & r;
      sop = a && (acc == 0);
      eop = a && (acc == PIX - 1);
      exp = {r, a, sop, eop, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stream mode%0d pix%0d: got %b want %b", mode, acc, obs, exp);
      end
      if (a) acc++;
      if (eop) begin
        acc = 0;
        eops++;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout mode%0d: got %0d pixels want %0d", mode, acc, PIX);
    end
  endtask

  // Checks the full stall after a frame end (or after reset release) plus the first COLLECT cycle.
  task automatic expect_stall(input logic hold_v, input bit from_reset);
    int n_load, n_drain, total, exp_addr;
    logic ld, cl, a;
    logic [7:0] exp;
    bit do_load;
    do_load = !from_reset && model_takes_load(eops - 1);
    n_load  = do_load ? BINS : 0;
    n_drain = do_load ? CDF_LAT : 0;
    total   = n_load + n_drain + BINS;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sink_valid = hold_v;
        source_ready = 1'b1;
      end
      #1;
      ld = (k < n_load);
      cl = (k >= n_load + n_drain);
      exp_addr = ld ? k : (k - n_load - n_drain);
      exp = {1'b0, 1'b0, 1'b0, 1'b0, ld, cl, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall k%0d: got %b want %b", k, obs, exp);
      end
      if (ld || cl) begin
        checks++;
        if (data_load_addr !== exp_addr[7:0]) begin
          errors++;
          $display("FAIL stall_addr k%0d: got %0d want %0d", k, data_load_addr, exp_addr);
        end
      end
    end
    @(negedge clk);
    #1;
    if (!from_reset) fc_exp = (fc_exp + 1) & 16'hFFFF;
    a = hold_v;
    exp = {1'b1, a, a, 1'b0, 1'b0, 1'b0, 1'b0, !from_reset};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stall_exit: got %b want %b", obs, exp);
    end
    checks++;
    if (frame_cnt !== fc_exp[15:0]) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, fc_exp);
    end
    if (a) acc = 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'b0000_0010 || data_load_addr !== 8'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL in_reset: got obs %b addr %0d cnt %0d want 00000010 0 0", obs, data_load_addr, frame_cnt);
    end
    acc = 0;
    fc_exp = 0;
    eops = 0;
    rst = 1'b1;
    expect_stall(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    sink_valid = 1'b1;
    source_ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_frame();
    stream_frame(0);
    expect_stall(1'b0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    stream_frame(1);
    expect_stall(1'b0, 1'b0);
  endtask

  task automatic test_random();
    repeat (3) begin
      stream_frame(2);
      expect_stall(1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    stream_frame(0);
    expect_stall(1'b1, 1'b0);
    stream_frame(0);
    expect_stall(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    stream_frame(0);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) sink_valid = 1'b0;
    end
    #1;
    checks++;
    if (data_load !== 1'b1 || data_load_addr !== 8'd100) begin
      errors++;
      $display("FAIL load_addr100: got load %b addr %0d want 1 100", data_load, data_load_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 8'b0000_0010 || data_load_addr !== 8'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got obs %b addr %0d cnt %0d want 00000010 0 0", obs, data_load_addr, frame_cnt);
    end
    acc = 0;
    fc_exp = 0;
    eops = 0;
    @(negedge clk);
    rst = 1'b1;
    expect_stall(1'b0, 1'b1);
    stream_frame(0);
    expect_stall(1'b0, 1'b0);
  endtask

  task automatic test_skip_sequence();
    sink_valid = 1'b0;
    apply_reset();
    for (int f = 0; f < 8; f++) begin
      stream_frame((f % 2 == 0) ? 0 : 2);
      expect_stall(1'b0, 1'b0);
    end
    checks++;
    if (frame_cnt !== 16'd8) begin
      errors++;
      $display("FAIL eight_frames: got %0d want 8", frame_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    sink_valid = 1'b0;
    source_ready = 1'b0;
    test_reset();
    test_frame();
    test_ready_toggle();
    test_random();
    test_back_to_back();
    test_reset_mid_load();
    test_skip_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors so far", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/hist_frame_ctrl.md
Name: hist_frame_ctrl

Overview:
- Frame sequencer for the gray-level histogram-equalisation pipeline. Blocks driven: pixel collector, CDF processor and LUT regenerator.
- Counts accepted pixels to generate frame sop/eop.
- Gates the sink handshake while the histogram RAM is in use, then sequences three phases per frame: bin readout into the CDF (LOAD), CDF pipeline drain (DRAIN), histogram RAM clear (CLEAR).

Parameters:
W, 960, active pixels per line
H, 540, active lines per frame
BINS, 256, histogram bins; address sweep length
CDF_LAT, 4, cycles from last load address to last CDF/LUT update
UPD_PERIOD, 4, frames per LUT recompute (used only with HIST_FRAME_SKIP_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sink_valid  in  1  upstream pixel valid
sink_ready  out  1  upstream pixel ready
source_ready  in  1  downstream ready
pix_accept  out  1  sink_valid & sink_ready; pixel consumed this cycle
sink_sop  out  1  combinational; high with the accepted first pixel of a frame
sink_eop  out  1  combinational; high with the accepted last pixel of a frame
data_load  out  1  histogram bin readout strobe to collector and CDF
data_load_addr  out  8  bin address for LOAD and CLEAR sweeps
clean  out  1  histogram RAM clear strobe, one bin per cycle
busy  out  1  high in any state other than COLLECT
frame_done  out  1  one-cycle pulse on the CLEAR to COLLECT transition
frame_cnt  out  16  completed frames, wraps 0xFFFF to 0

Behaviour:
- Reset (rst low, async): state=CLEAR, col=0, row=0, sweep address=0, skip count=0, frame_cnt=0.
  - Registered outputs reset to 0: data_load, data_load_addr, frame_done.
  - clean is asserted on the first clock after rst releases. This clears RAM at power-up and after any mid-operation reset, including reset during LOAD.
- sink_ready = source_ready & (state==COLLECT); combinational. pix_accept follows the same rule.
- Position counters advance only on pix_accept. col wraps W-1 to 0 and then increments row. row wraps H-1 to 0.
  - sink_sop = pix_accept & col==0 & row==0.
  - sink_eop = pix_accept & col==W-1 & row==H-1.
  - When source_ready or sink_valid drops, the counters hold.
- COLLECT: on sink_eop, go to LOAD on the next cycle (go to CLEAR instead when the frame is skipped). No other exit.
- LOAD: BINS cycles with data_load=1 and data_load_addr=0,1,...,BINS-1, one address per cycle, registered.
  - After address BINS-1, go to DRAIN. data_load drops in the same cycle.
- DRAIN: CDF_LAT cycles, all strobes low, then go to CLEAR.
- CLEAR: BINS cycles with clean=1 and data_load_addr=0..BINS-1, then go to COLLECT.
  - On that transition: frame_done=1 for one cycle and frame_cnt+1. Exception: a reset-entered CLEAR does not increment frame_cnt or pulse frame_done.
- Per-frame stall = 2*BINS+CDF_LAT cycles (516 at default).
- data_load and clean are never high in the same cycle. busy = (state!=COLLECT).
- A sink_valid arriving in a non-COLLECT state waits; no pixel is dropped or counted.

Optional Feature:
HIST_FRAME_SKIP_EN
- Defined: an internal skip counter (0..UPD_PERIOD-1) advances at each sink_eop.
  - The frame whose eop sees count==0 takes LOAD and DRAIN.
  - Other frames go COLLECT to CLEAR directly; the LUT keeps its previous contents.
  - frame_cnt counts all frames.
- Undefined: every frame takes LOAD and DRAIN; UPD_PERIOD is ignored.

Test Plan:
1. Reset release with W=4, H=2, BINS=256, CDF_LAT=4 -> clean=1 for 256 cycles, addr 0..255; sink_ready=0 throughout; then COLLECT; frame_cnt=0 and no frame_done pulse.
2. Stream 8 pixels with sink_valid=source_ready=1 -> sink_sop on pixel 0, sink_eop on pixel 7. Next cycle: LOAD 256 cycles, then 4 idle DRAIN cycles, then 256 CLEAR cycles. frame_done pulses once and frame_cnt=1.
3. Toggle source_ready low every third cycle mid-frame -> sink_ready follows, counters hold, sink_eop still lands on the 8th accepted pixel.
4. Hold sink_valid=1 through LOAD, DRAIN and CLEAR -> pix_accept=0 for all 516 cycles; the first accepted pixel after frame_done carries sink_sop.
5. Assert rst at LOAD address 100 -> on release: CLEAR from address 0, col=row=0, frame_cnt unchanged from reset value 0.
6. HIST_FRAME_SKIP_EN, UPD_PERIOD=4, run 8 frames -> LOAD occurs only after frames 1 and 5; frame_cnt=8.
